// File: rtl/cpu_host_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_host_seq_if
// Brief    : Bundles the operand-load stream, the data-memory port, the CPU
//            run handshake, the result stream and the status signals of
//            cpu_host_seq.
//            master : the sequencer (cpu_host_seq) side
//            slave  : the surrounding system (loader, memory, CPU, consumer)
// Revision : 1.0  initial release
// ============================================================================
interface cpu_host_seq_if;
    // Run control
    logic        start;
    // Operand byte stream
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    // Data-memory port
    logic        mem_wr_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wr_data;
    logic [7:0]  mem_rd_data;
    // CPU run handshake
    logic        req;
    logic        done;
    // Result byte stream
    logic        res_valid;
    logic [7:0]  res_data;
    logic        res_ready;
    // Status
    logic        busy;
    logic        timeout_err;
    logic [15:0] cycle_count;

    modport master (
        input  start, ld_valid, ld_data, mem_rd_data, done, res_ready,
        output ld_ready, mem_wr_en, mem_addr, mem_wr_data, req,
               res_valid, res_data, busy, timeout_err, cycle_count
    );

    modport slave (
        output start, ld_valid, ld_data, mem_rd_data, done, res_ready,
        input  ld_ready, mem_wr_en, mem_addr, mem_wr_data, req,
               res_valid, res_data, busy, timeout_err, cycle_count
    );
endinterface
`default_nettype wire

// File: rtl/cpu_host_seq.sv
`default_nettype none
// ============================================================================
// Module   : cpu_host_seq
// Brief    : Host-side run sequencer for a small CPU. Streams LOAD_N operand
//            bytes into data memory, pulses req, counts RUN cycles until done
//            (or aborts on TIMEOUT), then reads RES_N result bytes starting at
//            RES_BASE and hands them out over a valid/ready stream.
// Revision : 1.0  initial release
// ============================================================================
module cpu_host_seq #(
    parameter int         LOAD_N   = 8,      // operand bytes per run, 1..255
    parameter logic [7:0] RES_BASE = 8'd64,  // first result address
    parameter int         RES_N    = 4,      // result bytes per run, 1..255
    parameter int         TIMEOUT  = 4096    // RUN-cycle abort limit, 1..65535
) (
    input  wire logic       clk,
    input  wire logic       reset,
    cpu_host_seq_if.master  bus
);

    localparam logic [7:0]  LAST_LD  = 8'(LOAD_N - 1);
    localparam logic [7:0]  LAST_RES = 8'(RES_N - 1);
    localparam logic [15:0] TO_LIM   = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_REQ   = 3'd2,
        S_RUN   = 3'd3,
        S_RADDR = 3'd4,
        S_RWAIT = 3'd5,
        S_OUT   = 3'd6
    } state_t;

    state_t      state_q;
    logic [7:0]  idx_q;
    logic [15:0] cnt_q;
    logic        terr_q;
    logic [7:0]  rdata_q;

    logic [15:0] cnt_d;
    logic        beat;

    // Saturating next value of the RUN cycle counter and the load-beat qualifier
    always_comb begin
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        beat  = (state_q == S_LOAD) && bus.ld_valid;
    end

    // Memory port: write only on a load beat, read address only in RADDR,
    // otherwise parked at zero so the bus is quiet between accesses.
    always_comb begin
        bus.mem_wr_en   = beat;
        bus.mem_wr_data = beat ? bus.ld_data : 8'd0;
        if (beat) begin
            bus.mem_addr = idx_q;
        end else if (state_q == S_RADDR) begin
            bus.mem_addr = RES_BASE + idx_q;
        end else begin
            bus.mem_addr = 8'd0;
        end
    end

    // Status and stream strobes decode directly from the state register
    assign bus.ld_ready    = (state_q == S_LOAD);
    assign bus.req         = (state_q == S_REQ);
    assign bus.res_valid   = (state_q == S_OUT);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.res_data    = rdata_q;
    assign bus.timeout_err = terr_q;
    assign bus.cycle_count = cnt_q;

    // Sequencer FSM with its byte index, cycle counter, error flag and result latch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 8'd0;
            cnt_q   <= 16'd0;
            terr_q  <= 1'b0;
            rdata_q <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Counter and error flag keep the last run's result here
                    if (bus.start) begin
                        state_q <= S_LOAD;
                        idx_q   <= 8'd0;
                        cnt_q   <= 16'd0;
                        terr_q  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (beat) begin
                        idx_q <= idx_q + 8'd1;
                        if (idx_q == LAST_LD) begin
                            state_q <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // done is deliberately not looked at here
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    cnt_q <= cnt_d;
                    // done takes precedence over a coincident timeout
                    if (bus.done) begin
                        state_q <= S_RADDR;
                        idx_q   <= 8'd0;
                    end else if (cnt_d >= TO_LIM) begin
                        terr_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_RADDR: begin
                    state_q <= S_RWAIT;
                end
                S_RWAIT: begin
                    // Memory returns data one cycle after the address
                    rdata_q <= bus.mem_rd_data;
                    state_q <= S_OUT;
                end
                S_OUT: begin
                    if (bus.res_ready) begin
                        if (idx_q == LAST_RES) begin
                            state_q <= S_IDLE;
                        end else begin
                            idx_q   <= idx_q + 8'd1;
                            state_q <= S_RADDR;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_host_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_host_seq
// Brief    : Self-checking bench for cpu_host_seq: nominal run, gapped load,
//            stale done, result backpressure, resets mid-run, and timeout on a
//            second instance built with TIMEOUT=16.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_host_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_host_seq_if ifm ();
    cpu_host_seq_if ift ();

    cpu_host_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifm.master)
    );

    cpu_host_seq #(.TIMEOUT(16)) dut_to (
        .clk   (clk),
        .reset (reset),
        .bus   (ift.master)
    );

    int checks   = 0;
    int failures = 0;

    // Data memory model for the main instance: written bytes land in wmem,
    // the result window 64..67 holds A0..A3, reads are registered.
    logic [7:0] wmem [256];
    int wr_cnt  = 0;
    int req_cnt = 0;

    function automatic logic [7:0] rd_model(input logic [7:0] a);
        if (a >= 8'd64 && a <= 8'd67) return 8'hA0 + (a - 8'd64);
        return wmem[a];
    endfunction

    always @(posedge clk) begin
        if (ifm.mem_wr_en) begin
            wmem[ifm.mem_addr] <= ifm.mem_wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (ifm.req) req_cnt <= req_cnt + 1;
        ifm.mem_rd_data <= rd_model(ifm.mem_addr);
    end

    assign ift.mem_rd_data = 8'h00;
    logic to_rv_seen = 1'b0;
    always @(posedge clk) if (ift.res_valid) to_rv_seen <= 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"},   32'(ifm.req), 0);
        check({tag, "_we"},    32'(ifm.mem_wr_en), 0);
        check({tag, "_ldrdy"}, 32'(ifm.ld_ready), 0);
        check({tag, "_rv"},    32'(ifm.res_valid), 0);
        check({tag, "_busy"},  32'(ifm.busy), 0);
        check({tag, "_terr"},  32'(ifm.timeout_err), 0);
        check({tag, "_cnt"},   32'(ifm.cycle_count), 0);
        check({tag, "_addr"},  32'(ifm.mem_addr), 0);
        check({tag, "_wd"},    32'(ifm.mem_wr_data), 0);
        check({tag, "_rd"},    32'(ifm.res_data), 0);
    endtask

    // Waits (bounded) for a result byte and accepts it; res_ready must be 1
    task automatic get_result(input string nm, input logic [7:0] exp);
        int n = 0;
        while (!ifm.res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_valid"}, 32'(ifm.res_valid), 1);
        check({nm, "_data"},  32'(ifm.res_data), 32'(exp));
        @(negedge clk);
    endtask

    // Back-to-back load of 8 bytes into the main instance, no checks
    task automatic load_bytes(input logic [7:0] base);
        for (int i = 0; i < 8; i++) begin
            ifm.ld_valid = 1'b1;
            ifm.ld_data  = 8'(base + 8'(i));
            @(negedge clk);
        end
        ifm.ld_valid = 1'b0;
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       exp_we;
        logic [7:0] exp_addr;
        logic [7:0] exp_wd;
    } vec_t;
    vec_t vecs [15];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] held;
        int n;

        // Gapped load: valid 1,0,1,0,...; idle cycles carry junk data that must not be written
        vecs[0]  = '{1'b1, 8'h30, 1'b1, 8'd0, 8'h30};
        vecs[1]  = '{1'b0, 8'hEE, 1'b0, 8'd0, 8'h00};
        vecs[2]  = '{1'b1, 8'h31, 1'b1, 8'd1, 8'h31};
        vecs[3]  = '{1'b0, 8'hEE, 1'b0, 8'd0, 8'h00};
        vecs[4]  = '{1'b1, 8'h32, 1'b1, 8'd2, 8'h32};
        vecs[5]  = '{1'b0, 8'hEE, 1'b0, 8'd0, 8'h00};
        vecs[6]  = '{1'b1, 8'h33, 1'b1, 8'd3, 8'h33};
        vecs[7]  = '{1'b0, 8'hEE, 1'b0, 8'd0, 8'h00};
        vecs[8]  = '{1'b1, 8'h34, 1'b1, 8'd4, 8'h34};
        vecs[9]  = '{1'b0, 8'hEE, 1'b0, 8'd0, 8'h00};
        vecs[10] = '{1'b1, 8'h35, 1'b1, 8'd5, 8'h35};
        vecs[11] = '{1'b0, 8'hEE, 1'b0, 8'd0, 8'h00};
        vecs[12] = '{1'b1, 8'h36, 1'b1, 8'd6, 8'h36};
        vecs[13] = '{1'b0, 8'hEE, 1'b0, 8'd0, 8'h00};
        vecs[14] = '{1'b1, 8'h37, 1'b1, 8'd7, 8'h37};

        reset = 1'b1;
        ifm.start = 0; ifm.ld_valid = 0; ifm.ld_data = 0; ifm.done = 0; ifm.res_ready = 0;
        ift.start = 0; ift.ld_valid = 0; ift.ld_data = 0; ift.done = 0; ift.res_ready = 1;
        repeat (3) @(negedge clk);
        check_reset("por");
        reset = 1'b0;

        // ---------------- Nominal run ----------------
        ifm.res_ready = 1'b1;
        ifm.start = 1'b1;
        @(negedge clk);
        ifm.start = 1'b0;
        check("nom_ldrdy", 32'(ifm.ld_ready), 1);
        check("nom_busy",  32'(ifm.busy), 1);
        for (int i = 0; i < 8; i++) begin
            ifm.ld_valid = 1'b1;
            ifm.ld_data  = 8'(8'h10 + 8'(i));
            #1;
            check($sformatf("nom_we%0d", i),   32'(ifm.mem_wr_en), 1);
            check($sformatf("nom_addr%0d", i), 32'(ifm.mem_addr), 32'(i));
            check($sformatf("nom_wd%0d", i),   32'(ifm.mem_wr_data), 32'(8'h10 + i));
            @(negedge clk);
        end
        ifm.ld_valid = 1'b0;
        check("nom_req", 32'(ifm.req), 1);
        check("nom_ldrdy_req", 32'(ifm.ld_ready), 0);
        @(negedge clk);
        check("nom_req_drop", 32'(ifm.req), 0);
        for (int k = 1; k <= 20; k++) begin
            ifm.done = (k == 20);
            @(negedge clk);
        end
        ifm.done = 1'b0;
        check("nom_cnt",   32'(ifm.cycle_count), 20);
        check("nom_raddr", 32'(ifm.mem_addr), 64);
        get_result("nom_r0", 8'hA0);
        get_result("nom_r1", 8'hA1);
        get_result("nom_r2", 8'hA2);
        get_result("nom_r3", 8'hA3);
        check("nom_idle",   32'(ifm.busy), 0);
        check("nom_reqcnt", 32'(req_cnt), 1);
        check("nom_wrcnt",  32'(wr_cnt), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("nom_mem%0d", i), 32'(wmem[i]), 32'(8'h10 + i));

        // ---------------- Gapped load, stale done, backpressure ----------------
        ifm.start = 1'b1;
        @(negedge clk);
        ifm.start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            ifm.ld_valid = vecs[i].v;
            ifm.ld_data  = vecs[i].d;
            #1;
            check($sformatf("vec%0d_we", i),   32'(ifm.mem_wr_en),   32'(vecs[i].exp_we));
            check($sformatf("vec%0d_addr", i), 32'(ifm.mem_addr),    32'(vecs[i].exp_addr));
            check($sformatf("vec%0d_wd", i),   32'(ifm.mem_wr_data), 32'(vecs[i].exp_wd));
            @(negedge clk);
        end
        ifm.ld_valid = 1'b0;
        check("gap_req", 32'(ifm.req), 1);
        check("gap_wrcnt", 32'(wr_cnt), 16);
        for (int i = 0; i < 8; i++)
            check($sformatf("gap_mem%0d", i), 32'(wmem[i]), 32'(8'h30 + i));
        // done already high in REQ and held through the first RUN cycle
        ifm.done = 1'b1;
        @(negedge clk);
        ifm.start = 1'b1;
        check("stale_run_busy", 32'(ifm.busy), 1);
        check("stale_run_addr", 32'(ifm.mem_addr), 0);
        check("stale_run_cnt",  32'(ifm.cycle_count), 0);
        @(negedge clk);
        ifm.done  = 1'b0;
        ifm.start = 1'b0;
        check("stale_cnt",   32'(ifm.cycle_count), 1);
        check("stale_raddr", 32'(ifm.mem_addr), 64);
        ifm.res_ready = 1'b0;
        n = 0;
        while (!ifm.res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        held = ifm.res_data;
        check("bp_first", 32'(held), 32'hA0);
        for (int c = 0; c < 5; c++) begin
            ifm.start = (c == 2);
            #1;
            check($sformatf("bp%0d_valid", c), 32'(ifm.res_valid), 1);
            check($sformatf("bp%0d_data", c),  32'(ifm.res_data), 32'(held));
            check($sformatf("bp%0d_addr", c),  32'(ifm.mem_addr), 0);
            @(negedge clk);
        end
        ifm.start = 1'b0;
        ifm.res_ready = 1'b1;
        @(negedge clk);
        check("bp_next_addr", 32'(ifm.mem_addr), 65);
        get_result("bp_r1", 8'hA1);
        get_result("bp_r2", 8'hA2);
        get_result("bp_r3", 8'hA3);
        check("bp_idle",   32'(ifm.busy), 0);
        check("bp_reqcnt", 32'(req_cnt), 2);

        // ---------------- Reset mid-RUN, with start in the same cycle ----------------
        ifm.start = 1'b1;
        @(negedge clk);
        ifm.start = 1'b0;
        load_bytes(8'h50);
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("mr_busy_before", 32'(ifm.busy), 1);
        reset = 1'b1;
        ifm.start = 1'b1;
        @(negedge clk);
        check_reset("rst_run");
        reset = 1'b0;
        ifm.start = 1'b0;
        @(negedge clk);
        check("rst_run_stay_idle", 32'(ifm.busy), 0);
        check("rst_run_reqcnt", 32'(req_cnt), 3);

        // ---------------- Reset mid-OUT ----------------
        ifm.res_ready = 1'b0;
        ifm.start = 1'b1;
        @(negedge clk);
        ifm.start = 1'b0;
        load_bytes(8'h60);
        ifm.done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ifm.done = 1'b0;
        n = 0;
        while (!ifm.res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mo_valid", 32'(ifm.res_valid), 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset("rst_out");
        reset = 1'b0;
        ifm.res_ready = 1'b1;

        // ---------------- Timeout on the TIMEOUT=16 instance ----------------
        ift.start = 1'b1;
        @(negedge clk);
        ift.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ift.ld_valid = 1'b1;
            ift.ld_data  = 8'(i);
            @(negedge clk);
        end
        ift.ld_valid = 1'b0;
        check("to_req", 32'(ift.req), 1);
        repeat (16) @(negedge clk);
        check("to_busy16",  32'(ift.busy), 1);
        check("to_terr16",  32'(ift.timeout_err), 0);
        check("to_cnt15",   32'(ift.cycle_count), 15);
        @(negedge clk);
        check("to_terr",    32'(ift.timeout_err), 1);
        check("to_cnt",     32'(ift.cycle_count), 16);
        check("to_busy",    32'(ift.busy), 0);
        check("to_no_rv",   32'(to_rv_seen), 0);
        repeat (3) @(negedge clk);
        check("to_hold_terr", 32'(ift.timeout_err), 1);
        check("to_hold_cnt",  32'(ift.cycle_count), 16);
        ift.start = 1'b1;
        @(negedge clk);
        ift.start = 1'b0;
        check("to_clr_terr", 32'(ift.timeout_err), 0);
        check("to_clr_cnt",  32'(ift.cycle_count), 0);
        check("to_clr_busy", 32'(ift.busy), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
